fetch_mem_bridge: RTL and testbench

Upstream neighbour of fetch_unit. Services its single-outstanding read port (mem_address/mem_datasize/mem_read -> mem_readdata/mem_done) against a 32-bit pipelined Avalon-MM master interface to on-board SDRAM/on-chip RAM. Converts MMIX big-endian byte/wyde/tetra/octa reads into one or two 32-bit bus beats, aligns addresses MMIX-style and zero-extends results. The same block is reusable for the load path.

---
 rtl/mmix_mem_pkg.sv | 13 +
 rtl/fetch_mem_bridge.sv | 77 +++++++
 tb/tb_fetch_mem_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmix_mem_pkg.sv
// mmix_mem_pkg: MMIX access sizes, address alignment and big-endian lane extraction
package mmix_mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_WYDE, SZ_TETRA, SZ_OCTA} mem_size_t;
  function automatic logic [63:0] align_addr(input logic [63:0] addr, input mem_size_t size);
    return addr & ~((64'd1 << size) - 64'd1);
  endfunction
  function automatic logic [63:0] extract_lane(input logic [31:0] word, input logic [1:0] offset, input mem_size_t size);
    logic [7:0] b;
    b = 8'(word >> {~offset, 3'b000});
    return size == SZ_BYTE ? {56'd0, b} :
           size == SZ_WYDE ? {48'd0, offset[1] ? word[15:0] : word[31:16]} : {32'd0, word};
  endfunction
endpackage

// File: rtl/fetch_mem_bridge.sv
// fetch_mem_bridge: single-outstanding MMIX read port (mem_*) to 32-bit pipelined Avalon-MM master (avm_*), one or two beats per read
module fetch_mem_bridge
  import mmix_mem_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       mem_address,
  input  logic [1:0]        mem_datasize,
  input  logic              mem_read,
  output logic [63:0]       mem_readdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;
  state_t            r_state;
  mem_size_t         r_size;
  logic [1:0]        r_off;
  logic [31:0]       r_word0;
  logic              r_armed;
  logic [ADDR_W-1:0] w_a;
  assign w_a = ADDR_W'(align_addr(mem_address, mem_size_t'(mem_datasize)));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_size       <= SZ_BYTE;
      r_off        <= 2'd0;
      r_word0      <= 32'd0;
      r_armed      <= 1'b1;
      avm_read     <= 1'b0;
      avm_address  <= '0;
      mem_done     <= 1'b0;
      mem_readdata <= 64'd0;
    end else begin
      mem_done <= 1'b0;
      if (!mem_read) r_armed <= 1'b1;
      case (r_state)
        IDLE: if (mem_read && r_armed) begin
          r_armed     <= 1'b0;
          r_size      <= mem_size_t'(mem_datasize);
          r_off       <= w_a[1:0];
          avm_address <= {w_a[ADDR_W-1:2], 2'b00};
          avm_read    <= 1'b1;
          r_state     <= REQ0;
        end
        REQ0, REQ1: if (!avm_waitrequest) begin
          avm_read <= 1'b0;
          r_state  <= r_state == REQ0 ? WAIT0 : WAIT1;
        end
        WAIT0: if (avm_readdatavalid) begin
          if (r_size == SZ_OCTA) begin
            r_word0     <= avm_readdata;
            avm_address <= avm_address + ADDR_W'(4);
            avm_read    <= 1'b1;
            r_state     <= REQ1;
          end else begin
            mem_readdata <= extract_lane(avm_readdata, r_off, r_size);
            mem_done     <= 1'b1;
            r_state      <= DONE;
          end
        end
        WAIT1: if (avm_readdatavalid) begin
          mem_readdata <= {r_word0, avm_readdata};
          mem_done     <= 1'b1;
          r_state      <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_mem_bridge.sv
// tb_fetch_mem_bridge: directed and random reads against a byte-level big-endian memory model with a stalling Avalon slave
module tb_fetch_mem_bridge;
  localparam int AW = 24;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   mem_address = 64'd0;
  logic [1:0]    mem_datasize = 2'd0;
  logic          mem_read = 1'b0;
  logic [63:0]   mem_readdata;
  logic          mem_done;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata = 32'd0;
  logic          avm_readdatavalid = 1'b0;
  logic [31:0]   mem [logic [AW-1:0]];
  logic [AW-1:0] acc_q [$];
  logic [AW-1:0] pend_addr = '0;
  logic [AW-1:0] stall_addr = '0;
  int stall_cfg = 0, lat_cfg = 1, stall_cnt = 0, pend_cnt = 0;
  int n_acc = 0, n_done = 0, n_chk = 0, n_fail = 0;
  logic [63:0] got;
  fetch_mem_bridge #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .mem_address(mem_address), .mem_datasize(mem_datasize),
    .mem_read(mem_read), .mem_readdata(mem_readdata), .mem_done(mem_done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction
  function automatic logic [7:0] byte_at(input logic [AW-1:0] b);
    return 8'(word_at({b[AW-1:2], 2'b00}) >> (8 * (3 - int'(b[1:0]))));
  endfunction
  function automatic logic [63:0] ref_read(input logic [63:0] addr, input logic [1:0] sz);
    int n = 1 << sz;
    logic [AW-1:0] a = addr[AW-1:0] & ~AW'(n - 1);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < n; i++) r = (r << 8) | 64'(byte_at(a + AW'(i)));
    return r;
  endfunction
  initial begin
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = word_at(pend_addr);
        end
      end
      if (avm_read) begin
        if (stall_cnt == 0) stall_addr = avm_address;
        else chk("stall_addr_hold", 64'(avm_address), 64'(stall_addr));
        if (stall_cnt < stall_cfg) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          avm_waitrequest = 1'b0;
          chk("one_outstanding", 64'(pend_cnt), 64'd0);
          chk("addr_word_aligned", 64'(avm_address[1:0]), 64'd0);
          pend_addr = avm_address;
          pend_cnt = lat_cfg;
          acc_q.push_back(avm_address);
          n_acc++;
          stall_cnt = 0;
        end
      end else begin
        if (stall_cnt != 0 && !reset) chk("read_held_in_stall", 64'(avm_read), 64'd1);
        avm_waitrequest = 1'b0;
        stall_cnt = 0;
      end
    end
  end
  initial forever begin
    @(posedge clk);
    if (mem_done) n_done++;
  end
  task automatic do_read(input logic [63:0] addr, input logic [1:0] sz, input int s, input int l,
                         input int hold, input string tag, output logic [63:0] res);
    logic [63:0] exp = ref_read(addr, sz);
    int beats = (sz == 2'd3) ? 2 : 1;
    int k = 1;
    int acc0 = n_acc;
    int done0 = n_done;
    stall_cfg = s;
    lat_cfg = l;
    mem_address = addr;
    mem_datasize = sz;
    mem_read = 1'b1;
    tick();
    mem_address = {$urandom, $urandom};
    mem_datasize = 2'($urandom);
    while (!mem_done && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_done"}, 64'(mem_done), 64'd1);
    chk({tag, "_data"}, mem_readdata, exp);
    chk({tag, "_lat"}, 64'(k), 64'(beats * (1 + s + l) + 1));
    chk({tag, "_beats"}, 64'(n_acc - acc0), 64'(beats));
    res = mem_readdata;
    tick();
    chk({tag, "_pulse"}, 64'(mem_done), 64'd0);
    chk({tag, "_ndone"}, 64'(n_done - done0), 64'd1);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_noread"}, 64'(avm_read), 64'd0);
      chk({tag, "_hold_stable"}, mem_readdata, exp);
      tick();
    end
    chk({tag, "_hold_noacc"}, 64'(n_acc - acc0), 64'(beats));
    mem_read = 1'b0;
    tick();
  endtask
  initial begin
    logic [7:0]  byte_exp [4];
    logic [63:0] a;
    int acc0, done0, k;
    byte_exp[0] = 8'hA1; byte_exp[1] = 8'hB2; byte_exp[2] = 8'hC3; byte_exp[3] = 8'hD4;
    mem[24'h001004] = 32'hDEADBEEF;
    mem[24'hF00000] = 32'hCAFECAFE;
    mem[24'hF00004] = 32'h12345678;
    mem[24'h002000] = 32'hA1B2C3D4;
    mem[24'h003000] = 32'h0BADF00D;
    mem[24'h004000] = 32'h55AA33CC;
    mem[24'h005000] = 32'h11112222;
    mem[24'h005004] = 32'h33334444;
    mem[24'h006000] = 32'h76543210;
    tick(); tick(); tick();
    chk("rst_avm_read", 64'(avm_read), 64'd0);
    chk("rst_avm_address", 64'(avm_address), 64'd0);
    chk("rst_mem_done", 64'(mem_done), 64'd0);
    chk("rst_mem_readdata", mem_readdata, 64'd0);
    reset = 1'b0;
    tick();
    acc_q.delete();
    do_read(64'h0000_0000_0000_1006, 2'd2, 0, 1, 0, "tetra", got);
    chk("tetra_addr", 64'(acc_q[0]), 64'h1004);
    chk("tetra_const", got, 64'h0000_0000_DEAD_BEEF);
    acc_q.delete();
    do_read(64'h8000_FFFF_FFF0_0003, 2'd3, 0, 1, 0, "octa", got);
    chk("octa_addr0", 64'(acc_q[0]), 64'hF00000);
    chk("octa_addr1", 64'(acc_q[1]), 64'hF00004);
    chk("octa_const", got, 64'hCAFE_CAFE_1234_5678);
    for (int o = 0; o < 4; o++) begin
      do_read(64'h2000 + 64'(o), 2'd0, 0, 1, 0, "byte", got);
      chk("byte_const", got, 64'(byte_exp[o]));
    end
    do_read(64'h2001, 2'd1, 0, 1, 0, "wyde0", got);
    chk("wyde0_const", got, 64'hA1B2);
    do_read(64'h2002, 2'd1, 0, 1, 0, "wyde2", got);
    chk("wyde2_const", got, 64'hC3D4);
    acc0 = n_acc;
    do_read(64'h3002, 2'd2, 4, 3, 0, "stall", got);
    chk("stall_one_read", 64'(n_acc - acc0), 64'd1);
    do_read(64'h4000, 2'd2, 0, 1, 5, "hold", got);
    do_read(64'h4000, 2'd2, 0, 1, 0, "rearm", got);
    for (int i = 0; i < 24; i++) begin
      a = (i == 0) ? 64'hFFFF_FFF8 : 64'h10_0000 + 64'($urandom_range(0, 255));
      mem[{a[AW-1:3], 3'b000}] = $urandom;
      mem[{a[AW-1:3], 3'b100}] = $urandom;
      do_read({32'($urandom), a[31:0]}, (i == 0) ? 2'd3 : 2'($urandom), $urandom_range(0, 2),
              $urandom_range(1, 3), $urandom_range(0, 2), "rand", got);
    end
    acc0 = n_acc;
    stall_cfg = 0;
    lat_cfg = 6;
    mem_address = 64'h5000;
    mem_datasize = 2'd3;
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    k = 0;
    while (n_acc - acc0 < 2 && k < 50) begin
      tick();
      k++;
    end
    chk("rst_mid_two_beats", 64'(n_acc - acc0), 64'd2);
    tick(); tick();
    done0 = n_done;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_avm_read", 64'(avm_read), 64'd0);
    chk("rst_mid_avm_address", 64'(avm_address), 64'd0);
    chk("rst_mid_mem_done", 64'(mem_done), 64'd0);
    chk("rst_mid_mem_readdata", mem_readdata, 64'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("rst_stale_delivered", 64'(pend_cnt), 64'd0);
    chk("rst_no_done", 64'(n_done - done0), 64'd0);
    chk("rst_idle_readdata", mem_readdata, 64'd0);
    do_read(64'h6000, 2'd2, 0, 1, 0, "post_rst", got);
    acc0 = n_acc;
    reset = 1'b1;
    mem_read = 1'b1;
    mem_address = 64'h1004;
    mem_datasize = 2'd2;
    tick();
    chk("rst_wins_read", 64'(avm_read), 64'd0);
    tick();
    chk("rst_wins_noacc", 64'(n_acc - acc0), 64'd0);
    reset = 1'b0;
    do_read(64'h1004, 2'd2, 1, 2, 0, "after_rst_req", got);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
